// File: rtl/codeword_loader_pkg.sv
// Shared constants and FSM encoding for the RS decoder front end.
// Reused by the loader, syndrome and correction stages.
package codeword_loader_pkg;

  localparam int CODEWORD_LEN = 255;
  localparam int SYMBOL_WIDTH = 8;
  localparam int ADDR_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } ld_state_t;

endpackage

// File: rtl/codeword_ram.sv
// Codeword buffer: one sync write port, one sync read port (1-cycle latency).
// Ports: clock, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data.
module codeword_ram #(
  parameter int depth = 255,
  parameter int width = 8,
  parameter int aw    = 8
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [aw-1:0]    wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [aw-1:0]    rd_addr,
  output logic [width-1:0] rd_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/codeword_loader.sv
// Loads one RS codeword into a buffer, strobes each symbol to the syndrome
// stage, then holds it for the correction stage until release_buf.
// Ports: clock/reset, in_valid/in_byte/in_ready upstream,
// new_data/recd/decoder_rd_addr to syndrome, codeword_loaded,
// corr_rd_en/corr_rd_addr/corr_rd_data and release_buf to correction.
module codeword_loader
  import codeword_loader_pkg::*;
#(
  parameter int codeword_length = CODEWORD_LEN,
  parameter int width           = SYMBOL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [width-1:0]      in_byte,
  output logic                  in_ready,
  output logic                  new_data,
  output logic [width-1:0]      recd,
  output logic [ADDR_WIDTH-1:0] decoder_rd_addr,
  output logic                  codeword_loaded,
  input  logic                  corr_rd_en,
  input  logic [ADDR_WIDTH-1:0] corr_rd_addr,
  output logic [width-1:0]      corr_rd_data,
  input  logic                  release_buf
);

  localparam logic [ADDR_WIDTH-1:0] last_idx =
    ADDR_WIDTH'(codeword_length - 1);

  ld_state_t             state;
  logic [ADDR_WIDTH-1:0] count;
  logic                  fire;
  logic                  rd_ok;
  logic                  ram_rd;
  logic                  rd_gate;
  logic [width-1:0]      ram_q;

  assign fire   = in_valid & in_ready;
  assign rd_ok  = corr_rd_addr <= last_idx;
  assign ram_rd = corr_rd_en & rd_ok & (state == ST_HOLD);

  // rd_gate qualifies the RAM output: zero outside HOLD or
  // after an out-of-range read, so stale RAM data never leaks.
  assign corr_rd_data = rd_gate ? ram_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      in_ready        <= 1'b0;
      new_data        <= 1'b0;
      recd            <= '0;
      decoder_rd_addr <= '0;
      codeword_loaded <= 1'b0;
      rd_gate         <= 1'b0;
    end else begin
      new_data <= 1'b0;

      if (state == ST_HOLD) begin
        if (corr_rd_en)
          rd_gate <= rd_ok;
      end else begin
        rd_gate <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          state    <= ST_LOAD;
          in_ready <= 1'b1;
        end
        ST_LOAD: begin
          if (fire) begin
            new_data        <= 1'b1;
            recd            <= in_byte;
            decoder_rd_addr <= count + 1'b1;
            count           <= count + 1'b1;
            // last symbol: loaded flag rises with its strobe
            if (count == last_idx) begin
              state           <= ST_HOLD;
              in_ready        <= 1'b0;
              codeword_loaded <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (release_buf) begin
            state           <= ST_IDLE;
            count           <= '0;
            codeword_loaded <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  codeword_ram #(
    .depth (codeword_length),
    .width (width),
    .aw    (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (fire),
    .wr_addr (count),
    .wr_data (in_byte),
    .rd_en   (ram_rd),
    .rd_addr (corr_rd_addr),
    .rd_data (ram_q)
  );

endmodule
